// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM SDRAM slave port between two masters.
// Client 0 is the framebuffer reader, client 1 is game logic. Commands are
// arbitrated in IDLE, registered onto the sdram_* bus and held in ISSUE until
// the SDRAM accepts them. Outstanding reads are tracked in a tag FIFO so each
// returning readdatavalid is routed to the client that issued the read.
//
// Optional build macro: SDRAM_ARB_FIXED_PRI_EN
//   defined   -> client 0 always wins when both clients are eligible
//   undefined -> round-robin between the two clients
//
// Handshake: a client holds address/read/write/data stable while its
// cN_waitrequest is high; the command is taken in the single cycle where
// cN_waitrequest is low, which is the cycle the SDRAM drops sdram_waitrequest
// while this client's command is on the bus.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = ISSUE) for checkers.

module sdram_port_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,

    input  logic [ADDR_W-1:0]     c0_address,
    input  logic                  c0_read,
    input  logic                  c0_write,
    input  logic [DATA_W-1:0]     c0_writedata,
    input  logic [DATA_W/8-1:0]   c0_byteenable,
    output logic                  c0_waitrequest,
    output logic [DATA_W-1:0]     c0_readdata,
    output logic                  c0_readdatavalid,

    input  logic [ADDR_W-1:0]     c1_address,
    input  logic                  c1_read,
    input  logic                  c1_write,
    input  logic [DATA_W-1:0]     c1_writedata,
    input  logic [DATA_W/8-1:0]   c1_byteenable,
    output logic                  c1_waitrequest,
    output logic [DATA_W-1:0]     c1_readdata,
    output logic                  c1_readdatavalid,

    output logic [ADDR_W-1:0]     sdram_address,
    output logic [DATA_W/8-1:0]   sdram_byteenable_n,
    output logic                  sdram_chipselect,
    output logic [DATA_W-1:0]     sdram_writedata,
    output logic                  sdram_read_n,
    output logic                  sdram_write_n,
    input  logic [DATA_W-1:0]     sdram_readdata,
    input  logic                  sdram_readdatavalid,
    input  logic                  sdram_waitrequest,

    output logic                  orphan_err,
    output logic                  dbg_state
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                cs_q, cs_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;

    logic [MAX_PENDING-1:0] tags_q, tags_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   orphan_q, orphan_d;

    logic room, elig0, elig1, pick1, sel_wr;
    logic accept, push, pop, head_tag;

    // A write wins over a simultaneous read; reads need a free tag slot.
    assign room  = (cnt_q < CNT_W'(MAX_PENDING));
    assign elig0 = c0_write | (c0_read & room);
    assign elig1 = c1_write | (c1_read & room);

`ifdef SDRAM_ARB_FIXED_PRI_EN
    // Client 0 has absolute priority; client 1 only gets idle slots.
    assign pick1 = elig1 & ~elig0;
`else
    logic rr_q, rr_d;   // 1 = client 1 is preferred on the next tie

    // On a tie the client that was not granted last goes first.
    assign pick1 = elig1 & (~elig0 | rr_q);
    assign rr_d  = accept ? ~gnt_q : rr_q;

    // Round-robin preference register, updated on every accepted command.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) rr_q <= 1'b0;
        else             rr_q <= rr_d;
    end
`endif

    assign sel_wr = pick1 ? c1_write : c0_write;

    assign accept = (state_q == ISSUE) & ~sdram_waitrequest;
    assign push   = accept & ~rd_n_q;
    assign pop    = sdram_readdatavalid & (cnt_q != '0);

    // FSM next-state and command register loading.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_n_d  = be_n_q;
        cs_d    = cs_q;
        rd_n_d  = rd_n_q;
        wr_n_d  = wr_n_q;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d = ISSUE;
                    gnt_d   = pick1;
                    cs_d    = 1'b1;
                    wr_n_d  = ~sel_wr;
                    rd_n_d  = sel_wr;
                    addr_d  = pick1 ? c1_address   : c0_address;
                    wdata_d = pick1 ? c1_writedata : c0_writedata;
                    be_n_d  = pick1 ? ~c1_byteenable : ~c0_byteenable;
                end
            end
            ISSUE: begin
                if (!sdram_waitrequest) begin
                    state_d = IDLE;
                    cs_d    = 1'b0;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    be_n_d  = '1;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered SDRAM command bus.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_n_q  <= '1;
            cs_q    <= 1'b0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_n_q  <= be_n_d;
            cs_q    <= cs_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

    // Tag FIFO next state: push the grant on read accept, pop on readdatavalid.
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        orphan_d = orphan_q;
        if (push) begin
            tags_d[wr_ptr_q] = gnt_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Data arriving with nothing outstanding is dropped and flagged.
        if (sdram_readdatavalid && (cnt_q == '0)) begin
            orphan_d = 1'b1;
        end
    end

    // Tag FIFO registers and the sticky orphan flag.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tags_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            tags_q   <= tags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
        end
    end

    assign head_tag = tags_q[rd_ptr_q];

    assign c0_waitrequest   = ~(accept & ~gnt_q);
    assign c1_waitrequest   = ~(accept &  gnt_q);
    assign c0_readdata      = sdram_readdata;
    assign c1_readdata      = sdram_readdata;
    assign c0_readdatavalid = pop & ~head_tag;
    assign c1_readdatavalid = pop &  head_tag;

    assign sdram_address      = addr_q;
    assign sdram_byteenable_n = be_n_q;
    assign sdram_chipselect   = cs_q;
    assign sdram_writedata    = wdata_q;
    assign sdram_read_n       = rd_n_q;
    assign sdram_write_n      = wr_n_q;

    assign orphan_err = orphan_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios, expected commands and read
// returns queued by the stimulus, checked by negedge monitors.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int CW = 1 + 1 + 1 + 1 + BW + AW + DW;
    localparam int RW = 2 + 2 * DW;

    logic          clk_clk;
    logic          reset_reset;
    logic [AW-1:0] c0_address, c1_address;
    logic          c0_read, c0_write, c1_read, c1_write;
    logic [DW-1:0] c0_writedata, c1_writedata;
    logic [BW-1:0] c0_byteenable, c1_byteenable;
    logic          c0_waitrequest, c1_waitrequest;
    logic [DW-1:0] c0_readdata, c1_readdata;
    logic          c0_readdatavalid, c1_readdatavalid;
    logic [AW-1:0] sdram_address;
    logic [BW-1:0] sdram_byteenable_n;
    logic          sdram_chipselect;
    logic [DW-1:0] sdram_writedata;
    logic          sdram_read_n, sdram_write_n;
    logic [DW-1:0] sdram_readdata;
    logic          sdram_readdatavalid;
    logic          sdram_waitrequest;
    logic          orphan_err;
    logic          dbg_state;

    logic [CW-1:0] exp_cmd_q[$];
    logic [RW-1:0] exp_rd_q[$];
    int checks = 0;
    int errors = 0;

    sdram_port_arbiter dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .c0_address(c0_address), .c0_read(c0_read), .c0_write(c0_write),
        .c0_writedata(c0_writedata), .c0_byteenable(c0_byteenable),
        .c0_waitrequest(c0_waitrequest), .c0_readdata(c0_readdata),
        .c0_readdatavalid(c0_readdatavalid),
        .c1_address(c1_address), .c1_read(c1_read), .c1_write(c1_write),
        .c1_writedata(c1_writedata), .c1_byteenable(c1_byteenable),
        .c1_waitrequest(c1_waitrequest), .c1_readdata(c1_readdata),
        .c1_readdatavalid(c1_readdatavalid),
        .sdram_address(sdram_address), .sdram_byteenable_n(sdram_byteenable_n),
        .sdram_chipselect(sdram_chipselect), .sdram_writedata(sdram_writedata),
        .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
        .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
        .sdram_waitrequest(sdram_waitrequest),
        .orphan_err(orphan_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected accepted command: type, strobes, per-client waitrequest, bus.
    function automatic logic [CW-1:0] mk_cmd(input bit c, input bit wr, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d, input logic [BW-1:0] be);
        return {wr, ~wr, ~c, c, ~be, a, (wr ? d : {DW{1'b0}})};
    endfunction

    // Expected read return: which client sees valid, and the broadcast data.
    function automatic logic [RW-1:0] mk_rd(input bit c, input bit valid, input logic [DW-1:0] d);
        return {valid & c, valid & ~c, d, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        tick(2);
        reset_reset = 1'b0;
        tick(1);
    endtask

    // Drive one Avalon command for client c and hold it until accepted.
    task automatic c_cmd(input bit c, input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
        bit done = 1'b0;
        if (!c) begin
            c0_write = wr; c0_read = rd; c0_address = a; c0_writedata = d; c0_byteenable = be;
        end else begin
            c1_write = wr; c1_read = rd; c1_address = a; c1_writedata = d; c1_byteenable = be;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk_clk);
            if ((c ? c1_waitrequest : c0_waitrequest) == 1'b0) done = 1'b1;
        end
        chk($sformatf("c%0d_cmd_accepted_%h", c, a), 64'(done), 64'(1));
        @(posedge clk_clk);
        #1;
        if (!c) begin c0_write = 1'b0; c0_read = 1'b0; end
        else    begin c1_write = 1'b0; c1_read = 1'b0; end
    endtask

    // One cycle of SDRAM read data; caller sits just after a rising edge.
    task automatic ret(input logic [DW-1:0] d);
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = d;
        @(posedge clk_clk);
        #1;
        sdram_readdatavalid = 1'b0;
    endtask

    task automatic wait_cs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_clk);
            if (sdram_chipselect) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_clk);
            if (sdram_chipselect && !sdram_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk_clk) begin
        if (sdram_chipselect && !sdram_waitrequest) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got addr %h, none expected", sdram_address);
            end else begin
                chk("cmd_accept",
                    64'({~sdram_write_n, ~sdram_read_n, c1_waitrequest, c0_waitrequest,
                         sdram_byteenable_n, sdram_address,
                         (~sdram_write_n ? sdram_writedata : {DW{1'b0}})}),
                    64'(exp_cmd_q.pop_front()));
            end
        end else begin
            chk("waitreq_idle", 64'({c1_waitrequest, c0_waitrequest}), 64'(2'b11));
        end

        if (sdram_readdatavalid) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got data %h, none expected", sdram_readdata);
            end else begin
                chk("rd_return",
                    64'({c1_readdatavalid, c0_readdatavalid, c1_readdata, c0_readdata}),
                    64'(exp_rd_q.pop_front()));
            end
        end else begin
            chk("rdv_quiet", 64'({c1_readdatavalid, c0_readdatavalid}), 64'(2'b00));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit ok;
        int ord[8];
        int n0, n1;

        reset_reset = 1'b1;
        c0_address = '0; c0_read = 1'b0; c0_write = 1'b0; c0_writedata = '0; c0_byteenable = '0;
        c1_address = '0; c1_read = 1'b0; c1_write = 1'b0; c1_writedata = '0; c1_byteenable = '0;
        sdram_readdata = '0; sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0;

        // Reset values
        tick(2);
        chk("reset_values",
            64'({sdram_chipselect, sdram_read_n, sdram_write_n, sdram_byteenable_n,
                 sdram_address, sdram_writedata, c1_waitrequest, c0_waitrequest,
                 c1_readdatavalid, c0_readdatavalid, orphan_err, dbg_state}),
            64'({1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        reset_reset = 1'b0;
        tick(1);

        // Single write with a two-cycle SDRAM stall
        exp_cmd_q.push_back(mk_cmd(1'b1, 1'b1, 25'h0000123, 16'hBEEF, 2'b01));
        sdram_waitrequest = 1'b1;
        fork
            c_cmd(1'b1, 1'b1, 1'b0, 25'h0000123, 16'hBEEF, 2'b01);
            begin
                wait_cs(ok);
                chk("t1_cs_seen", 64'(ok), 64'(1));
                chk("t1_stall_cycle1",
                    64'({c1_waitrequest, sdram_chipselect, sdram_write_n, sdram_read_n,
                         sdram_byteenable_n, sdram_address, sdram_writedata}),
                    64'({1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 25'h0000123, 16'hBEEF}));
                @(posedge clk_clk);
                #1;
                @(negedge clk_clk);
                chk("t1_stall_cycle2",
                    64'({c1_waitrequest, sdram_chipselect, sdram_write_n, sdram_read_n,
                         sdram_byteenable_n, sdram_address, sdram_writedata}),
                    64'({1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 25'h0000123, 16'hBEEF}));
                @(posedge clk_clk);
                #1;
                sdram_waitrequest = 1'b0;
                @(negedge clk_clk);
                chk("t1_accept_cycle3",
                    64'({c1_waitrequest, sdram_chipselect, sdram_write_n, sdram_read_n,
                         sdram_byteenable_n, sdram_address, sdram_writedata}),
                    64'({1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 25'h0000123, 16'hBEEF}));
            end
        join
        chk("t1_back_idle", 64'({sdram_chipselect, sdram_write_n, sdram_byteenable_n}),
            64'({1'b0, 1'b1, 2'b11}));

        // Contention: both clients read continuously
        do_reset();
        for (int k = 0; k < 8; k++) begin
`ifdef SDRAM_ARB_FIXED_PRI_EN
            ord[k] = (k < 4) ? 0 : 1;
`else
            ord[k] = k % 2;
`endif
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (ord[k] == 0) begin
                exp_cmd_q.push_back(mk_cmd(1'b0, 1'b0, AW'(32'h100 + n0), 16'h0, 2'b11));
                n0++;
            end else begin
                exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, AW'(32'h200 + n1), 16'h0, 2'b11));
                n1++;
            end
            exp_rd_q.push_back(mk_rd(ord[k] != 0, 1'b1, DW'(k + 1)));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) c_cmd(1'b0, 1'b0, 1'b1, AW'(32'h100 + i), 16'h0, 2'b11);
            end
            begin
                for (int i = 0; i < 4; i++) c_cmd(1'b1, 1'b0, 1'b1, AW'(32'h200 + i), 16'h0, 2'b11);
            end
            begin
                for (int k = 1; k <= 8; k++) begin
                    bit acc;
                    wait_accept(acc);
                    chk($sformatf("t2_accept_%0d", k), 64'(acc), 64'(1));
                    @(posedge clk_clk);
                    #1;
                    ret(DW'(k));
                end
            end
        join

        // FIFO full: fifth read blocked, a write still goes through
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_cmd_q.push_back(mk_cmd(1'b0, 1'b0, AW'(32'h300 + i), 16'h0, 2'b11));
            c_cmd(1'b0, 1'b0, 1'b1, AW'(32'h300 + i), 16'h0, 2'b11);
        end
        exp_cmd_q.push_back(mk_cmd(1'b1, 1'b1, 25'h00003AA, 16'h1234, 2'b11));
        exp_cmd_q.push_back(mk_cmd(1'b0, 1'b0, 25'h0000304, 16'h0, 2'b11));
        fork
            c_cmd(1'b0, 1'b0, 1'b1, 25'h0000304, 16'h0, 2'b11);
            begin
                repeat (4) begin
                    @(negedge clk_clk);
                    chk("t3_full_blocks_read", 64'(sdram_chipselect), 64'(0));
                end
                @(posedge clk_clk);
                #1;
                c_cmd(1'b1, 1'b1, 1'b0, 25'h00003AA, 16'h1234, 2'b11);
                repeat (2) begin
                    @(negedge clk_clk);
                    chk("t3_still_blocked", 64'(sdram_chipselect), 64'(0));
                end
                @(posedge clk_clk);
                #1;
                exp_rd_q.push_back(mk_rd(1'b0, 1'b1, 16'h00A1));
                ret(16'h00A1);
                @(negedge clk_clk);
                chk("t3_release_idle", 64'(sdram_chipselect), 64'(0));
                @(negedge clk_clk);
                chk("t3_release_issue", 64'({sdram_chipselect, sdram_read_n, sdram_address}),
                    64'({1'b1, 1'b0, 25'h0000304}));
            end
        join
        for (int i = 0; i < 4; i++) begin
            exp_rd_q.push_back(mk_rd(1'b0, 1'b1, DW'(32'h00A2 + i)));
            ret(DW'(32'h00A2 + i));
        end
        // read and write together behave as a write
        exp_cmd_q.push_back(mk_cmd(1'b0, 1'b1, 25'h00003CC, 16'h5A5A, 2'b10));
        c_cmd(1'b0, 1'b1, 1'b1, 25'h00003CC, 16'h5A5A, 2'b10);

        // Same-cycle push and pop at count 2
        do_reset();
        exp_cmd_q.push_back(mk_cmd(1'b0, 1'b0, 25'h0000400, 16'h0, 2'b11));
        c_cmd(1'b0, 1'b0, 1'b1, 25'h0000400, 16'h0, 2'b11);
        exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 25'h0000401, 16'h0, 2'b11));
        c_cmd(1'b1, 1'b0, 1'b1, 25'h0000401, 16'h0, 2'b11);
        exp_cmd_q.push_back(mk_cmd(1'b0, 1'b0, 25'h0000402, 16'h0, 2'b11));
        sdram_waitrequest = 1'b1;
        fork
            c_cmd(1'b0, 1'b0, 1'b1, 25'h0000402, 16'h0, 2'b11);
            begin
                wait_cs(ok);
                chk("t4_cs_seen", 64'(ok), 64'(1));
                @(posedge clk_clk);
                #1;
                sdram_waitrequest = 1'b0;
                exp_rd_q.push_back(mk_rd(1'b0, 1'b1, 16'h0C01));
                ret(16'h0C01);
            end
        join
        exp_rd_q.push_back(mk_rd(1'b1, 1'b1, 16'h0C02));
        ret(16'h0C02);
        exp_rd_q.push_back(mk_rd(1'b0, 1'b1, 16'h0C03));
        ret(16'h0C03);
        chk("t4_no_orphan_yet", 64'(orphan_err), 64'(0));
        exp_rd_q.push_back(mk_rd(1'b0, 1'b0, 16'h0DDD));
        ret(16'h0DDD);
        chk("t4_extra_is_orphan", 64'(orphan_err), 64'(1));

        // Reset during ISSUE with two reads pending
        do_reset();
        chk("t5_orphan_cleared", 64'(orphan_err), 64'(0));
        exp_cmd_q.push_back(mk_cmd(1'b0, 1'b0, 25'h0000500, 16'h0, 2'b11));
        c_cmd(1'b0, 1'b0, 1'b1, 25'h0000500, 16'h0, 2'b11);
        exp_cmd_q.push_back(mk_cmd(1'b1, 1'b0, 25'h0000501, 16'h0, 2'b11));
        c_cmd(1'b1, 1'b0, 1'b1, 25'h0000501, 16'h0, 2'b11);
        sdram_waitrequest = 1'b1;
        c0_write = 1'b1; c0_address = 25'h00005FF; c0_writedata = 16'h7777; c0_byteenable = 2'b11;
        wait_cs(ok);
        chk("t5_cs_seen", 64'({ok, dbg_state}), 64'(2'b11));
        #1;
        reset_reset = 1'b1;
        #1;
        chk("t5_async_reset",
            64'({sdram_chipselect, sdram_read_n, sdram_write_n, sdram_byteenable_n,
                 sdram_address, sdram_writedata, c1_waitrequest, c0_waitrequest,
                 c1_readdatavalid, c0_readdatavalid, orphan_err, dbg_state}),
            64'({1'b0, 1'b1, 1'b1, 2'b11, 25'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        c0_write = 1'b0;
        sdram_waitrequest = 1'b0;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        tick(1);
        exp_rd_q.push_back(mk_rd(1'b0, 1'b0, 16'h0E01));
        ret(16'h0E01);
        chk("t5_stray_sets_orphan", 64'(orphan_err), 64'(1));

        tick(3);
        chk("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'(0));
        chk("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 16-bit Avalon-MM SDRAM slave port of the RAM subsystem between two masters: client 0 (display/framebuffer reader) and client 1 (game-logic read/write).
- Arbitrates commands, drives the active-low SDRAM command signals, and tracks outstanding pipelined reads in a tag FIFO so each readdatavalid is routed back to its issuing client.
- Sits between the game/display logic and the RAM subsystem's sdram_* port, in the clk143 domain.

Parameters:
ADDR_W, 25, word address width
DATA_W, 16, data width; byte-enable width BE_W = DATA_W/8
MAX_PENDING, 4, maximum outstanding reads; power of 2, >= 2

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous reset, active-high
cN_address  in  ADDR_W  client N address (N = 0,1; each cN_ port is one port per client)
cN_read  in  1  client N read request
cN_write  in  1  client N write request
cN_writedata  in  DATA_W  client N write data
cN_byteenable  in  BE_W  client N byte enables, active-high
cN_waitrequest  out  1  low exactly in the cycle client N's command is accepted
cN_readdata  out  DATA_W  read data, broadcast to both clients
cN_readdatavalid  out  1  read data valid for client N
sdram_address  out  ADDR_W  registered command address
sdram_byteenable_n  out  BE_W  inverted byte enables
sdram_chipselect  out  1  command valid
sdram_writedata  out  DATA_W  registered write data
sdram_read_n  out  1  read strobe, active-low
sdram_write_n  out  1  write strobe, active-low
sdram_readdata  in  DATA_W  SDRAM read data
sdram_readdatavalid  in  1  SDRAM read data valid
sdram_waitrequest  in  1  SDRAM stall
orphan_err  out  1  sticky: readdatavalid received with no pending read

Behaviour:
- Clock and reset: one clock, clk_clk; reset_reset is asynchronous, active-high.
- Reset values: state IDLE; chipselect 0; read_n 1; write_n 1; byteenable_n all ones; address and writedata 0; tag FIFO empty; round-robin pointer favours client 0; orphan_err 0; both readdatavalid 0; both waitrequest 1.
- FSM IDLE:
  - Candidate = client with read or write asserted.
  - A read candidate is eligible only if pending count < MAX_PENDING.
  - If two clients are eligible, round-robin picks the client not granted last.
  - Winner's command is latched into the sdram_* registers (chipselect=1, read_n/write_n per request, byteenable_n = ~byteenable). The grant index is latched. Go to ISSUE.
  - If no client is eligible, stay in IDLE with outputs idle.
- FSM ISSUE:
  - Command held stable while sdram_waitrequest=1.
  - On sdram_waitrequest=0 the command is accepted: the granted client's waitrequest is 0 in that same cycle (combinational from sdram_waitrequest); the round-robin pointer is updated; a read pushes the grant tag into the FIFO; registers return to idle values; next state is IDLE.
- Latency: request seen in IDLE at cycle t gives chipselect at t+1; earliest accept at t+1. Peak throughput is one command per 2 cycles.
- Clients hold their command stable until their waitrequest is low (Avalon rule).
- read and write asserted together are treated as a write; the read is ignored.
- Read return:
  - On sdram_readdatavalid, pop the FIFO head tag and assert cTAG_readdatavalid for one cycle; readdata passes through combinationally.
  - Push and pop in the same cycle is legal; count unchanged.
  - Pop with the FIFO empty: drop the data, set orphan_err (cleared only by reset).
  - FIFO pointers wrap modulo MAX_PENDING.
- Reset mid-command: the command is abandoned and pending tags are lost. Subsequent stray readdatavalids set orphan_err.

Optional Feature:
SDRAM_ARB_FIXED_PRI_EN
- Defined: client 0 always wins when both are eligible; round-robin pointer unused. Guarantees framebuffer bandwidth; client 1 may starve.
- Undefined: round-robin as described.

Test Plan:
- Single write: c1 write addr 0x0000123, data 0xBEEF, be 2'b01, waitrequest held 2 cycles -> sdram write_n=0, byteenable_n=2'b10, command stable 3 cycles, c1_waitrequest low only in the accept cycle.
- Contention: c0 and c1 both read continuously, no stall -> grants alternate 0,1,0,1; each client's readdatavalid is correct in order for returned data 0x0001..0x0008.
- FIFO full: MAX_PENDING=4, four c0 reads accepted with no data returned -> fifth read not issued (chipselect 0), a c1 write is still issued; the first readdatavalid releases the read on the next IDLE.
- Same-cycle push and pop: read accept coincides with readdatavalid at count 2 -> count stays 2; tags are routed correctly.
- Orphan and reset: assert reset_reset during ISSUE with 2 reads pending -> outputs return to reset values immediately; next sdram_readdatavalid sets orphan_err=1 and no client readdatavalid is asserted.
- With SDRAM_ARB_FIXED_PRI_EN: both clients request reads continuously -> c0 granted every time, c1 never granted.
